// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder, with locked multi-word carry chains.
// Optional signed-overflow output o_rsp_ovf is enabled by defining ADDER_SHARE_ARB_OVF_EN.

module adder_cla_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        g,
  output logic        p
);

  logic [31:0] bit_g;
  logic [31:0] bit_p;
  logic [31:0] carry;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;
  logic        all_g;

  // Nibble lookahead: group generate/propagate per 4 bits, group carries chained across nibbles.
  always_comb begin
    bit_g = a & b;
    bit_p = a ^ b;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    carry = '0;
    all_g = 1'b0;
    for (int n = 0; n < 8; n++) begin
      grp_g[n] = bit_g[4*n+3]
               | (bit_p[4*n+3] & bit_g[4*n+2])
               | (bit_p[4*n+3] & bit_p[4*n+2] & bit_g[4*n+1])
               | (bit_p[4*n+3] & bit_p[4*n+2] & bit_p[4*n+1] & bit_g[4*n]);
      grp_p[n] = &bit_p[4*n +: 4];
    end
    grp_c[0] = cin;
    for (int n = 0; n < 8; n++) begin
      grp_c[n+1] = grp_g[n] | (grp_p[n] & grp_c[n]);
      all_g      = grp_g[n] | (grp_p[n] & all_g);
    end
    for (int n = 0; n < 8; n++) begin
      carry[4*n] = grp_c[n];
      for (int j = 1; j < 4; j++) begin
        carry[4*n+j] = bit_g[4*n+j-1] | (bit_p[4*n+j-1] & carry[4*n+j-1]);
      end
    end
    sum  = bit_p ^ carry;
    cout = grp_c[8];
    g    = all_g;
    p    = &grp_p;
  end

endmodule

module adder_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*32-1:0] i_req_a,
  input  logic [NUM_REQ*32-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]    i_req_cin,
  input  logic [NUM_REQ-1:0]    i_req_chain,
  input  logic [NUM_REQ-1:0]    i_req_lock,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [31:0]           o_rsp_sum,
  output logic                  o_rsp_cout,
  output logic                  o_rsp_g,
  output logic                  o_rsp_p
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic                  o_rsp_ovf
`endif
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            carry_q, carry_d;

  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   idx_ext;
  logic            grant_hit;
  logic            free;
  logic            accept;
  logic [31:0]     sel_a, sel_b;
  logic            sel_valid, sel_cin, sel_chain, sel_lock;
  logic            add_cin;
  logic [31:0]     add_sum;
  logic            add_cout, add_g, add_p;

  assign free = ~o_rsp_valid | i_rsp_ready;

  // Wrapping search from the pointer; a locked owner holds the grant even while idle.
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    idx_ext   = '0;
    if (state_q == ST_LOCKED) begin
      grant_idx = owner_q;
      grant_hit = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx_ext = {1'b0, ptr_q} + (ID_W+1)'(i);
        if (idx_ext >= (ID_W+1)'(NUM_REQ)) begin
          idx_ext = idx_ext - (ID_W+1)'(NUM_REQ);
        end
        if (!grant_hit && i_req_valid[idx_ext[ID_W-1:0]]) begin
          grant_idx = idx_ext[ID_W-1:0];
          grant_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_valid   = 1'b0;
    sel_cin     = 1'b0;
    sel_chain   = 1'b0;
    sel_lock    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        o_req_ready[k] = grant_hit & free & i_rst_n;
        sel_a          = i_req_a[32*k +: 32];
        sel_b          = i_req_b[32*k +: 32];
        sel_valid      = i_req_valid[k];
        sel_cin        = i_req_cin[k];
        sel_chain      = i_req_chain[k];
        sel_lock       = i_req_lock[k];
      end
    end
  end

  assign accept  = grant_hit & free & i_rst_n & sel_valid;
  assign add_cin = sel_chain ? carry_q : sel_cin;

  adder_cla_32b u_adder (
    .a    (sel_a),
    .b    (sel_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .g    (add_g),
    .p    (add_p)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    carry_d = carry_q;
    if (accept) begin
      carry_d = add_cout;
      if (sel_lock) begin
        state_d = ST_LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = ST_UNLOCKED;
        ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      carry_q <= carry_d;
    end
  end

  // A new acceptance overwrites the slot, which is only possible when the old response drains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_sum   <= '0;
      o_rsp_cout  <= 1'b0;
      o_rsp_g     <= 1'b0;
      o_rsp_p     <= 1'b0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      o_rsp_ovf   <= 1'b0;
`endif
    end else if (accept) begin
      o_rsp_valid <= 1'b1;
      o_rsp_id    <= grant_idx;
      o_rsp_sum   <= add_sum;
      o_rsp_cout  <= add_cout;
      o_rsp_g     <= add_g;
      o_rsp_p     <= add_p;
`ifdef ADDER_SHARE_ARB_OVF_EN
      o_rsp_ovf   <= (sel_a[31] == sel_b[31]) && (add_sum[31] != sel_a[31]);
`endif
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed vector table, hand sequences, and random traffic vs a reference model.
// Checks o_rsp_ovf as well when ADDER_SHARE_ARB_OVF_EN is defined.

module tb_adder_share_arb;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ*32-1:0] i_req_a;
  logic [NUM_REQ*32-1:0] i_req_b;
  logic [NUM_REQ-1:0]    i_req_cin;
  logic [NUM_REQ-1:0]    i_req_chain;
  logic [NUM_REQ-1:0]    i_req_lock;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [ID_W-1:0]       o_rsp_id;
  logic [31:0]           o_rsp_sum;
  logic                  o_rsp_cout;
  logic                  o_rsp_g;
  logic                  o_rsp_p;
`ifdef ADDER_SHARE_ARB_OVF_EN
  logic                  o_rsp_ovf;
`endif

  always #5 i_clk = ~i_clk;

  adder_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_cin   (i_req_cin),
    .i_req_chain (i_req_chain),
    .i_req_lock  (i_req_lock),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_sum   (o_rsp_sum),
    .o_rsp_cout  (o_rsp_cout),
    .o_rsp_g     (o_rsp_g),
    .o_rsp_p     (o_rsp_p)
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    .o_rsp_ovf   (o_rsp_ovf)
`endif
  );

  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] v_vec, cin_vec, chain_vec, lock_vec;
  logic               rsp_rdy;
  logic [NUM_REQ-1:0] last_ready;

  int          m_ptr, m_owner, m_id;
  bit          m_locked, m_carry, m_valid, m_cout, m_g, m_p, m_ovf;
  logic [31:0] m_sum;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [7];

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] modelReady();
    logic [NUM_REQ-1:0] r;
    bit free;
    int k;
    r = '0;
    free = !m_valid || rsp_rdy;
    if (i_rst_n) begin
      if (m_locked) begin
        r[m_owner] = free;
      end else begin
        for (int off = 0; off < NUM_REQ; off++) begin
          k = (m_ptr + off) % NUM_REQ;
          if (v_vec[k]) begin
            r[k] = free;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    m_ptr = 0; m_owner = 0; m_locked = 0; m_carry = 0;
    m_valid = 0; m_id = 0; m_sum = '0; m_cout = 0; m_g = 0; m_p = 0; m_ovf = 0;
  endtask

  task automatic modelEdge();
    logic [NUM_REQ-1:0] take;
    logic [32:0] full;
    bit ci;
    int gi;
    take = modelReady() & v_vec;
    gi = -1;
    for (int k = 0; k < NUM_REQ; k++) if (take[k]) gi = k;
    if (gi >= 0) begin
      ci      = chain_vec[gi] ? m_carry : cin_vec[gi];
      full    = {1'b0, a_arr[gi]} + {1'b0, b_arr[gi]} + 33'(ci);
      m_valid = 1;
      m_id    = gi;
      m_sum   = full[31:0];
      m_cout  = full[32];
      m_g     = (({1'b0, a_arr[gi]} + {1'b0, b_arr[gi]}) >> 32) != 0;
      m_p     = (a_arr[gi] ^ b_arr[gi]) == 32'hFFFF_FFFF;
      m_ovf   = (a_arr[gi][31] == b_arr[gi][31]) && (full[31] != a_arr[gi][31]);
      m_carry = full[32];
      if (lock_vec[gi]) begin
        m_locked = 1;
        m_owner  = gi;
      end else begin
        m_locked = 0;
        m_ptr    = (gi + 1) % NUM_REQ;
      end
    end else if (m_valid && rsp_rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic checkOutput();
    checkEq("rsp_valid", o_rsp_valid, m_valid);
    if (m_valid) begin
      checkEq("rsp_id", o_rsp_id, m_id);
      checkEq("rsp_sum", o_rsp_sum, m_sum);
      checkEq("rsp_cout", o_rsp_cout, m_cout);
      checkEq("rsp_g", o_rsp_g, m_g);
      checkEq("rsp_p", o_rsp_p, m_p);
`ifdef ADDER_SHARE_ARB_OVF_EN
      checkEq("rsp_ovf", o_rsp_ovf, m_ovf);
`endif
    end
  endtask

  // Drives one cycle of stimulus from the arrays, checks ready before the edge and the slot after it.
  task automatic applyStimulus();
    i_req_valid = v_vec;
    i_req_cin   = cin_vec;
    i_req_chain = chain_vec;
    i_req_lock  = lock_vec;
    i_rsp_ready = rsp_rdy;
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_a[32*k +: 32] = a_arr[k];
      i_req_b[32*k +: 32] = b_arr[k];
    end
    #1;
    last_ready = o_req_ready;
    checkEq("req_ready", o_req_ready, modelReady());
    @(posedge i_clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    i_rst_n = 1'b0;
    #1;
    modelReset();
    checkEq("reset_rsp_valid", o_rsp_valid, 0);
    checkEq("reset_req_ready", o_req_ready, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic clearCtl();
    v_vec = '0; cin_vec = '0; chain_vec = '0; lock_vec = '0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1, 4'b0001, 32'h0000_0001, 32'hFFFF_FFFF, 0, 4'b0001, 2'd0, 32'h0000_0000, 1};
    vecs[1] = '{1, 4'b1111, 32'h0000_0100, 32'h0000_0001, 0, 4'b0001, 2'd0, 32'h0000_0101, 0};
    vecs[2] = '{0, 4'b1111, 32'h0000_0100, 32'h0000_0001, 1, 4'b0010, 2'd1, 32'h0000_0112, 0};
    vecs[3] = '{0, 4'b1111, 32'h0000_0100, 32'h0000_0001, 0, 4'b0100, 2'd2, 32'h0000_0121, 0};
    vecs[4] = '{0, 4'b1111, 32'h0000_0100, 32'h0000_0001, 0, 4'b1000, 2'd3, 32'h0000_0131, 0};
    vecs[5] = '{0, 4'b1111, 32'h0000_0100, 32'h0000_0001, 0, 4'b0001, 2'd0, 32'h0000_0101, 0};
    vecs[6] = '{0, 4'b0110, 32'h8000_0000, 32'h8000_0000, 0, 4'b0010, 2'd1, 32'h0000_0010, 1};

    clearCtl();
    rsp_rdy = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin a_arr[k] = '0; b_arr[k] = '0; end
    v_vec = 4'b1111;
    i_req_valid = v_vec;
    i_req_a = '0; i_req_b = '0; i_req_cin = '0; i_req_chain = '0; i_req_lock = '0;
    i_rsp_ready = 1'b1;
    resetDut();
    checkEq("reset_rsp_id", o_rsp_id, 0);
    checkEq("reset_rsp_sum", o_rsp_sum, 0);
    checkEq("reset_rsp_flags", {o_rsp_cout, o_rsp_g, o_rsp_p}, 0);

    // Directed table: requester k sees operand a + 0x10*k so the operand mux is visible in the sum.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) resetDut();
      clearCtl();
      v_vec = vecs[i].valid;
      cin_vec = {NUM_REQ{vecs[i].cin}};
      rsp_rdy = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        a_arr[k] = vecs[i].a + 32'(16 * k);
        b_arr[k] = vecs[i].b;
      end
      applyStimulus();
      checkEq("vec_ready", last_ready, vecs[i].exp_ready);
      checkEq("vec_valid", o_rsp_valid, 1);
      checkEq("vec_id", o_rsp_id, vecs[i].exp_id);
      checkEq("vec_sum", o_rsp_sum, vecs[i].exp_sum);
      checkEq("vec_cout", o_rsp_cout, vecs[i].exp_cout);
    end

    // Back-pressure: slot holds id1 sum 0x10 while the consumer stalls.
    clearCtl();
    v_vec = 4'b0010; a_arr[1] = 32'h55; b_arr[1] = 32'h11; rsp_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkEq("bp_ready", last_ready, 0);
      checkEq("bp_hold_sum", o_rsp_sum, 32'h10);
    end
    rsp_rdy = 1'b1;
    applyStimulus();
    checkEq("bp_release_ready", last_ready, 4'b0010);
    checkEq("bp_release_sum", o_rsp_sum, 32'h66);

    // 64-bit chain on requester 2 while requester 0 competes.
    clearCtl();
    v_vec = 4'b0101; lock_vec = 4'b0100;
    a_arr[2] = 32'hFFFF_FFFF; b_arr[2] = 32'h1; a_arr[0] = 32'h7; b_arr[0] = 32'h7;
    applyStimulus();
    checkEq("chain1_ready", last_ready, 4'b0100);
    checkEq("chain1_sum", o_rsp_sum, 0);
    checkEq("chain1_cout", o_rsp_cout, 1);
    v_vec = 4'b0001;
    applyStimulus();
    checkEq("chain_idle_owner_ready", last_ready, 4'b0100);
    v_vec = 4'b0101; lock_vec = '0; chain_vec = 4'b0100;
    a_arr[2] = '0; b_arr[2] = '0;
    applyStimulus();
    checkEq("chain2_sum", o_rsp_sum, 32'h1);
    checkEq("chain2_id", o_rsp_id, 2);
    v_vec = 4'b1001; chain_vec = '0; a_arr[3] = 32'h3; b_arr[3] = 32'h4;
    applyStimulus();
    checkEq("after_chain_ready", last_ready, 4'b1000);

    // Reset while locked with the slot full; stored carry must return to 0.
    clearCtl();
    v_vec = 4'b0010; lock_vec = 4'b0010; a_arr[1] = 32'hFFFF_FFFF; b_arr[1] = 32'h1;
    applyStimulus();
    v_vec = '0; rsp_rdy = 1'b0;
    applyStimulus();
    #2;
    resetDut();
    clearCtl();
    rsp_rdy = 1'b1;
    v_vec = 4'b0010; chain_vec = 4'b0010; cin_vec = 4'b0010;
    a_arr[1] = 32'h5; b_arr[1] = 32'h5;
    applyStimulus();
    checkEq("post_reset_ready", last_ready, 4'b0010);
    checkEq("post_reset_sum", o_rsp_sum, 32'hA);

`ifdef ADDER_SHARE_ARB_OVF_EN
    clearCtl();
    v_vec = 4'b0001; a_arr[0] = 32'h7FFF_FFFF; b_arr[0] = 32'h1;
    applyStimulus();
    checkEq("ovf_set_sum", o_rsp_sum, 32'h8000_0000);
    checkEq("ovf_set", o_rsp_ovf, 1);
    a_arr[0] = 32'hFFFF_FFFF;
    applyStimulus();
    checkEq("ovf_clear", o_rsp_ovf, 0);
`endif

    // Random traffic against the reference model, including locks, chains and stalls.
    for (int c = 0; c < 400; c++) begin
      v_vec     = NUM_REQ'($urandom);
      cin_vec   = NUM_REQ'($urandom);
      chain_vec = NUM_REQ'($urandom);
      lock_vec  = NUM_REQ'($urandom) & NUM_REQ'($urandom);
      rsp_rdy   = ($urandom_range(3) != 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        a_arr[k] = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
        b_arr[k] = ($urandom_range(3) == 0) ? 32'h0000_0001 : $urandom;
      end
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
